motion_map_packer: RTL and testbench
====================================

# motion_map_packer

Downstream stage of the per-pixel motion detector in the motion map generator. It collects the one-bit motion decisions, one per accepted pixel in raster order, and packs them into WORD_W-bit motion-map words with line and frame markers. A 2-entry output FIFO absorbs memory-side backpressure. The block also reports the per-frame count of motion pixels.

## Interface
- FRAME_W, default 640: pixels per line, ≥ 1.
- FRAME_H, default 480: lines per frame, ≥ 1.
- WORD_W, default 32: bits per output word, ≥ 2.
- CNT_W, default $clog2(FRAME_W*FRAME_H+1): width of the motion counter.
- clk  input  1  single clock; all logic is posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  motion bit valid (the registered detector enable).
- in_motion  input  1  motion bit from the detector.
- in_sof  input  1  marks the first pixel of a frame; sampled only on an accepted beat.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- m_data  output  WORD_W  packed word; pixel k of the word sits at bit k (LSB first).
- m_valid  output  1  m_data holds a word.
- m_ready  input  1  consumer accepts; a word transfers when m_valid && m_ready.
- m_eol  output  1  word is the last word of a line.
- m_eof  output  1  word is the last word of a frame; implies m_eol.
- frame_done  output  1  one-cycle pulse at frame end.
- frame_motion_cnt  output  CNT_W  motion-pixel count of the last completed frame.
- sync_err  output  1  one-cycle pulse on an early in_sof.

## Operation
- Reset values: in_ready=1, m_valid=0, m_data=0, m_eol=0, m_eof=0, frame_done=0, frame_motion_cnt=0, sync_err=0. The FIFO is empty and all counters are 0.
- Counters:
  - col runs 0..FRAME_W-1.
  - row runs 0..FRAME_H-1.
  - bit_idx runs 0..WORD_W-1.
  - acc is a WORD_W-bit accumulator.
  - mcnt is the CNT_W-bit motion count.
- Accepted beat: acc[bit_idx] = in_motion; mcnt += in_motion; col increments.
- Word completion occurs when bit_idx==WORD_W-1 or col==FRAME_W-1.
  - The completed word (acc including the current bit) is pushed into the FIFO with eol=(col==FRAME_W-1) and eof=(eol && row==FRAME_H-1).
  - bits above bit_idx are 0, so a partial end-of-line word is zero-padded.
  - acc and bit_idx clear after the push.
- Words never span lines; each line starts at bit 0 of a fresh word.
- End of line: col wraps to 0 and row increments.
- End of frame: row wraps to 0; frame_motion_cnt <= mcnt + in_motion; mcnt clears; frame_done pulses.
- in_sof handling:
  - in_sof on an accepted beat while (col,row)==(0,0) has no extra effect.
  - in_sof while (col,row)!=(0,0):
    - discard the partial acc (no word is pushed);
    - do not update frame_motion_cnt and do not pulse frame_done;
    - pulse sync_err;
    - treat the beat as pixel (0,0) of a new frame, with mcnt restarting at in_motion.
- A missing in_sof is not an error; the counters alone define frame boundaries.
- FIFO:
  - Two entries; the head drives m_data, m_eol and m_eof from registers.
  - in_ready = (fifo_count != 2). It depends only on registered state, not on m_ready.
  - A push and a pop in the same cycle leave the count unchanged and keep order.
  - m_data, m_eol and m_eof stay stable while m_valid && !m_ready.
- When the FIFO is full, in_ready=0 and no beat is accepted, so no bit is ever lost.
- Asynchronous reset mid-frame or mid-word drops all state, including FIFO contents, and returns every output to its reset value.

## Timing
- The beat that completes a word is accepted in cycle N. With an empty FIFO, m_valid=1 with that word in cycle N+1.
- frame_done, frame_motion_cnt and sync_err update in cycle N+1 after the triggering beat. frame_done coincides with the eof word becoming visible if the FIFO was empty.
- Throughput: one bit per cycle sustained while m_ready=1.
- in_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from a full FIFO.

## Test plan
- Reset, idle: hold rst_n=0, release, drive no beats -> in_ready=1, m_valid=0, all outputs 0.
- Full frame: FRAME_W=40, FRAME_H=2, WORD_W=32, m_ready=1, continuous beats, in_motion=1 on pixels 0, 31, 39 of line 0 and none on line 1, in_sof on the first beat -> four words:
  - 0x80000001 (eol=0);
  - 0x00000080 (eol=1);
  - 0x00000000 (eol=0);
  - 0x00000000 (eol=1, eof=1).
  - Also frame_done pulses once and frame_motion_cnt=3.
- Backpressure: same stream with m_ready=0 for 100 cycles -> in_ready=0 after 2 pushed words; m_data is stable; no word is lost or duplicated once m_ready=1.
- Early sof: in_sof asserted at col=10 of line 0 -> sync_err pulses once, no partial word is emitted, frame_done does not pulse, and the next frame packs correctly from bit 0.
- Simultaneous push/pop: FIFO count=1, m_ready=1, with a word-completing beat in the same cycle -> count stays 1, in_ready stays 1, words arrive in order.
- Reset mid-word: assert rst_n=0 at col=17 with 1 word queued -> m_valid=0 immediately, and after release the next frame's first word starts at bit 0.

Source files
------------

// File: rtl/motion_map_packer.sv
// motion_map_packer
//
// Packs one-bit motion decisions, arriving one per accepted pixel in raster
// order, into WORD_W-bit words (pixel k of a word at bit k). Words never span
// lines: the last word of each line is zero-padded and tagged m_eol, and the
// last word of a frame is also tagged m_eof. A 2-entry FIFO holds finished
// words against consumer backpressure. The block also reports the motion
// count of every completed frame and flags an in_sof that arrives mid-frame.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; a beat is accepted when both are 1
//   in_motion           motion bit of the accepted pixel
//   in_sof              first pixel of a frame (sampled on accepted beats)
//   m_data/m_eol/m_eof  head word of the FIFO and its line/frame markers
//   m_valid/m_ready     output handshake
//   frame_done          one-cycle pulse when a frame completes
//   frame_motion_cnt    motion count of the last completed frame
//   sync_err            one-cycle pulse when in_sof arrives mid-frame
`timescale 1ns/1ps
module motion_map_packer #(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int WORD_W  = 32,
    parameter int CNT_W   = $clog2(FRAME_W*FRAME_H+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_motion,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_eol,
    output logic              m_eof,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_motion_cnt,
    output logic              sync_err
);

    localparam int COL_W = $clog2(FRAME_W+1);
    localparam int ROW_W = $clog2(FRAME_H+1);
    localparam int BIT_W = $clog2(WORD_W);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_W-1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H-1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W-1);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [BIT_W-1:0]  bit_idx;
    logic [WORD_W-1:0] acc;
    logic [CNT_W-1:0]  mcnt;

    logic [1:0]        fifo_count;
    logic [WORD_W-1:0] tail_data;
    logic              tail_eol;
    logic              tail_eof;

    logic              accept;
    logic              restart;
    logic [COL_W-1:0]  eff_col;
    logic [ROW_W-1:0]  eff_row;
    logic [BIT_W-1:0]  eff_bit;
    logic [WORD_W-1:0] eff_acc;
    logic [CNT_W-1:0]  eff_mcnt;
    logic [WORD_W-1:0] word_acc;
    logic              line_end;
    logic              frame_end;
    logic              word_end;
    logic              push;
    logic              pop;

    // Ready/valid decode only registered FIFO occupancy, so in_ready never
    // depends combinationally on m_ready.
    assign in_ready = (fifo_count != 2'd2);
    assign m_valid  = (fifo_count != 2'd0);

    always_comb begin
        accept   = in_valid && in_ready;
        // An in_sof away from (0,0) abandons the current frame: the beat is
        // handled as if the position counters and accumulator were already
        // cleared, so the partial word and partial count simply vanish.
        restart  = in_sof && ((col != '0) || (row != '0));
        eff_col  = restart ? '0 : col;
        eff_row  = restart ? '0 : row;
        eff_bit  = restart ? '0 : bit_idx;
        eff_acc  = restart ? '0 : acc;
        eff_mcnt = restart ? '0 : mcnt;

        // Bits above eff_bit are always zero, which gives the padding of a
        // short end-of-line word for free.
        word_acc          = eff_acc;
        word_acc[eff_bit] = in_motion;

        line_end  = (eff_col == COL_LAST);
        frame_end = line_end && (eff_row == ROW_LAST);
        word_end  = line_end || (eff_bit == BIT_LAST);

        push = accept && word_end;
        pop  = m_valid && m_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col              <= '0;
            row              <= '0;
            bit_idx          <= '0;
            acc              <= '0;
            mcnt             <= '0;
            frame_done       <= 1'b0;
            frame_motion_cnt <= '0;
            sync_err         <= 1'b0;
            fifo_count       <= 2'd0;
            m_data           <= '0;
            m_eol            <= 1'b0;
            m_eof            <= 1'b0;
            tail_data        <= '0;
            tail_eol         <= 1'b0;
            tail_eof         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;

            if (accept) begin
                sync_err <= restart;
                col      <= line_end ? '0 : eff_col + 1'b1;
                if (frame_end)
                    row <= '0;
                else if (line_end)
                    row <= eff_row + 1'b1;
                else
                    row <= eff_row;
                bit_idx  <= word_end ? '0 : eff_bit + 1'b1;
                acc      <= word_end ? '0 : word_acc;

                if (frame_end) begin
                    frame_motion_cnt <= eff_mcnt + CNT_W'(in_motion);
                    mcnt             <= '0;
                    frame_done       <= 1'b1;
                end else begin
                    mcnt <= eff_mcnt + CNT_W'(in_motion);
                end
            end

            // Head register drives the outputs; tail holds the second word.
            // A push can only coincide with a pop when exactly one word is
            // held, so the new word replaces the departing head.
            if (push && pop) begin
                m_data <= word_acc;
                m_eol  <= line_end;
                m_eof  <= frame_end;
            end else if (push) begin
                if (fifo_count == 2'd0) begin
                    m_data <= word_acc;
                    m_eol  <= line_end;
                    m_eof  <= frame_end;
                end else begin
                    tail_data <= word_acc;
                    tail_eol  <= line_end;
                    tail_eof  <= frame_end;
                end
                fifo_count <= fifo_count + 2'd1;
            end else if (pop) begin
                if (fifo_count == 2'd2) begin
                    m_data <= tail_data;
                    m_eol  <= tail_eol;
                    m_eof  <= tail_eof;
                end
                fifo_count <= fifo_count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_motion_map_packer.sv
`timescale 1ns/1ps
module tb_motion_map_packer;

    localparam int FW = 40;
    localparam int FH = 2;
    localparam int WW = 32;
    localparam int CW = $clog2(FW*FH+1);

    typedef struct packed {
        logic          eof;
        logic          eol;
        logic [WW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_motion = 1'b0;
    logic          in_sof = 1'b0;
    logic          m_ready = 1'b0;
    logic          in_ready;
    logic [WW-1:0] m_data;
    logic          m_valid;
    logic          m_eol;
    logic          m_eof;
    logic          frame_done;
    logic [CW-1:0] frame_motion_cnt;
    logic          sync_err;

    motion_map_packer #(
        .FRAME_W(FW),
        .FRAME_H(FH),
        .WORD_W (WW),
        .CNT_W  (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_motion       (in_motion),
        .in_sof          (in_sof),
        .in_ready        (in_ready),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_eol           (m_eol),
        .m_eof           (m_eof),
        .frame_done      (frame_done),
        .frame_motion_cnt(frame_motion_cnt),
        .sync_err        (sync_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame position is a single pixel index; a word is emitted whenever a
    // WORD_W-aligned slice of the current line is filled or the line ends.
    word_t exp_q[$];
    int    mp = 0;
    int    mc = 0;
    logic  mline[FW];
    logic  exp_fd = 1'b0;
    logic  exp_se = 1'b0;
    int    exp_cnt = 0;
    bit    m_rdy;
    int    m_col, m_row, m_base;
    word_t m_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            mp = 0; mc = 0; exp_fd = 0; exp_se = 0; exp_cnt = 0;
        end else begin
            exp_fd = 0;
            exp_se = 0;
            m_rdy = (exp_q.size() < 2);
            if (exp_q.size() > 0 && m_ready) void'(exp_q.pop_front());
            if (in_valid && m_rdy) begin
                if (in_sof && mp != 0) begin
                    exp_se = 1; mp = 0; mc = 0;
                end
                m_col = mp % FW;
                m_row = mp / FW;
                mline[m_col] = in_motion;
                mc += int'(in_motion);
                if ((m_col % WW) == WW-1 || m_col == FW-1) begin
                    m_base = m_col - (m_col % WW);
                    m_w = '0;
                    for (int k = m_base; k <= m_col; k++) m_w.data[k-m_base] = mline[k];
                    m_w.eol = (m_col == FW-1);
                    m_w.eof = m_w.eol && (m_row == FH-1);
                    exp_q.push_back(m_w);
                end
                mp++;
                if (mp == FW*FH) begin
                    mp = 0; exp_fd = 1; exp_cnt = mc; mc = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare + monitors ----------------
    int    fd_cnt = 0;
    int    se_cnt = 0;
    word_t log_q[$];

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        chk("m_valid", 64'(m_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("m_data", 64'(m_data), 64'(exp_q[0].data));
            chk("m_eol", 64'(m_eol), 64'(exp_q[0].eol));
            chk("m_eof", 64'(m_eof), 64'(exp_q[0].eof));
        end
        chk("frame_done", 64'(frame_done), 64'(exp_fd));
        chk("sync_err", 64'(sync_err), 64'(exp_se));
        chk("frame_motion_cnt", 64'(frame_motion_cnt), 64'(exp_cnt));
        fd_cnt += int'(frame_done === 1'b1);
        se_cnt += int'(sync_err === 1'b1);
    end

    always @(posedge clk) begin
        if (rst_n && m_valid === 1'b1 && m_ready) log_q.push_back({m_eof, m_eol, m_data});
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic pat_bit(input int pat, input int p);
        case (pat)
            0:       return (p == 0 || p == 31 || p == 39);
            1:       return (p == 1 || p == 35 || p >= 40);
            default: return 1'b1;
        endcase
    endfunction

    task automatic beat(input logic m, input logic s);
        int g;
        in_valid = 1'b1; in_motion = m; in_sof = s;
        g = 0;
        while (in_ready !== 1'b1 && g < 500) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 500) chk("beat_accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_motion = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_range(input int pat, input int lo, input int hi);
        for (int p = lo; p <= hi; p++) beat(pat_bit(pat, p), p == 0);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (m_valid === 1'b1 && g < 300) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 300) chk("drain_timeout", 64'd1, 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input word_t e0, input word_t e1,
                          input word_t e2, input word_t e3);
        word_t e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_word_count"}, 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < log_q.size()) chk($sformatf("%s_word%0d", tag, i), 64'(log_q[i]), 64'(e[i]));
    endtask

    localparam word_t A0 = {1'b0, 1'b0, 32'h8000_0001};
    localparam word_t A1 = {1'b0, 1'b1, 32'h0000_0080};
    localparam word_t A2 = {1'b0, 1'b0, 32'h0000_0000};
    localparam word_t A3 = {1'b1, 1'b1, 32'h0000_0000};
    localparam word_t B0 = {1'b0, 1'b0, 32'h0000_0002};
    localparam word_t B1 = {1'b0, 1'b1, 32'h0000_0008};
    localparam word_t B2 = {1'b0, 1'b0, 32'hFFFF_FFFF};
    localparam word_t B3 = {1'b1, 1'b1, 32'h0000_00FF};

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_eol_eof", 64'({m_eol, m_eof}), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_cnt", 64'(frame_motion_cnt), 64'd0);
        chk("rst_sync_err", 64'(sync_err), 64'd0);

        // Full frame, no backpressure
        m_ready = 1'b1; log_q.delete(); fd_cnt = 0;
        send_range(0, 0, 31);
        chk("first_word_latency", 64'({m_valid, m_data}), 64'({1'b1, 32'h8000_0001}));
        send_range(0, 32, 79);
        chk("frame_done_at_end", 64'(frame_done), 64'd1);
        chk("frame_cnt_full", 64'(frame_motion_cnt), 64'd3);
        drain();
        check4("full", A0, A1, A2, A3);
        chk("full_frame_done_count", 64'(fd_cnt), 64'd1);

        // Backpressure for 100 cycles
        m_ready = 1'b0; log_q.delete(); fd_cnt = 0;
        fork
            send_range(0, 0, 79);
            begin
                repeat (60) @(posedge clk);
                #1;
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                chk("bp_head_held", 64'({m_valid, m_data}), 64'({1'b1, 32'h8000_0001}));
                repeat (40) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        drain();
        check4("bp", A0, A1, A2, A3);
        chk("bp_cnt", 64'(frame_motion_cnt), 64'd3);
        chk("bp_frame_done_count", 64'(fd_cnt), 64'd1);

        // Early sof at col 10 of line 0
        m_ready = 1'b1; log_q.delete(); fd_cnt = 0; se_cnt = 0;
        send_range(2, 1, 10);
        beat(pat_bit(0, 0), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("esof_sync_err_count", 64'(se_cnt), 64'd1);
        chk("esof_no_frame_done", 64'(fd_cnt), 64'd0);
        chk("esof_no_partial_word", 64'(log_q.size()), 64'd0);
        send_range(0, 1, 79);
        drain();
        check4("esof", A0, A1, A2, A3);
        chk("esof_cnt", 64'(frame_motion_cnt), 64'd3);
        chk("esof_frame_done_count", 64'(fd_cnt), 64'd1);
        chk("esof_sync_err_final", 64'(se_cnt), 64'd1);

        // Push and pop in the same cycle with one word held
        m_ready = 1'b0; log_q.delete();
        send_range(1, 0, 38);
        m_ready = 1'b1;
        beat(pat_bit(1, 39), 1'b0);
        chk("pp_in_ready", 64'(in_ready), 64'd1);
        chk("pp_head", 64'({m_valid, m_eol, m_data}), 64'({1'b1, 1'b1, 32'h0000_0008}));
        send_range(1, 40, 79);
        drain();
        check4("pp", B0, B1, B2, B3);
        chk("pp_cnt", 64'(frame_motion_cnt), 64'd42);

        // Reset at col 17 of line 1 with one word queued
        m_ready = 1'b0;
        send_range(0, 0, 39);
        m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        send_range(0, 40, 56);
        chk("pre_rst_queued", 64'(m_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_cnt", 64'(frame_motion_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        log_q.delete(); m_ready = 1'b1;
        send_range(0, 0, 79);
        drain();
        check4("postrst", A0, A1, A2, A3);
        chk("postrst_cnt", 64'(frame_motion_cnt), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
